mix_sequencer: RTL and testbench
================================

MIX_SEQUENCER -- requirements
Module: mix_sequencer

Interface
REQ-001 Parameter: W, 32, state-word width in bits.
REQ-002 Parameter: NREG, 8, number of state registers; fixed at 8, index width 3.
REQ-003 Port: clk  in  1  single clock, rising-edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  request one mixing job; sampled only in IDLE.
REQ-006 Port: rounds  in  8  number of MIX rounds; captured when start is accepted.
REQ-007 Port: seed_we  in  1  write seed_data into state register seed_idx; honoured only in IDLE.
REQ-008 Port: seed_idx  in  3  seed write index.
REQ-009 Port: seed_data  in  W  seed write value.
REQ-010 Port: rd_idx  in  3  read index.
REQ-011 Port: rd_data  out  W  combinational read of state register rd_idx.
REQ-012 Port: busy  out  1  high in ADD, MIX and SCALE.
REQ-013 Port: done  out  1  one-cycle pulse in DONE.

Function
REQ-014 FSM states: IDLE, ADD, MIX, SCALE, DONE; a 3-bit index i steps 0..7 within each phase, one register updated per cycle on one shared datapath.
REQ-015 IDLE: start=1 captures rounds into round counter R, sets i=0, next state ADD.
REQ-016 ADD, 8 cycles: o[i] = o[i] + i.
REQ-017 MIX, 8*R cycles: o[i] = o[i] + o[(i-1) mod 8] - o[(i-2) mod 8]; each update uses values already written earlier in the same pass.
REQ-018 SCALE, 8 cycles: o[i] = o[i]*K[i] + C[i], with K = {2,3,5,7,11,13,17,19} and C = {3,5,7,11,13,17,19,23}.
REQ-019 Arithmetic: all results are truncated to W bits, modulo 2^W, unsigned, with no saturation or flags.
REQ-020 Transitions: ADD at i=7 goes to MIX if R!=0, else to SCALE. MIX at i=7 decrements R; if R becomes 0, go to SCALE. SCALE at i=7 goes to DONE. DONE goes to IDLE after 1 cycle.
REQ-021 Latency: start sampled at edge k gives done=1 for the cycle following edge k+16+8*R; busy=0 during DONE.
REQ-022 rounds=0 skips MIX entirely, for a total of 17 cycles from start to done.
REQ-023 start outside IDLE, including DONE, is ignored and not queued.
REQ-024 seed_we outside IDLE is ignored and the state is unchanged.
REQ-025 seed_we and start in the same IDLE cycle: the write completes at that edge, and the ADD update of o[0] sees the written value.
REQ-026 rd_data is valid in all states; a mid-job read returns the partially updated value.
REQ-027 rounds=255 yields 2040 MIX cycles; the counter must not wrap.

Reset
REQ-028 rst_n low asynchronously forces: state=IDLE, i=0, R=0, o[n]=n for n=0..7, busy=0, done=0.
REQ-029 Reset asserted mid-job aborts it; no done pulse is produced for the aborted job.
REQ-030 After rst_n rises, the first start is accepted on the next rising edge.

Structure
REQ-031 Shared package mix_pkg holds the FSM state enum, the K/C constant tables, W and the index width.
REQ-032 Sub-module mix_alu shall be used: combinational, inputs a, b, c, k and an op select, output a+b-c (ADD/MIX) or a*k+c (SCALE); exactly one instance.

Verification
REQ-033 Reset, seed left at defaults, start with rounds=0 -> done 17 cycles later; rd_data[0..7] = 3, 11, 27, 53, 101, 147, 223, 289.
REQ-034 Reset, start with rounds=1 -> done 25 cycles later; o = 7, 0xFFFFFFE7, 0xFFFFFFDF, 67, 277, 355, 257, 61.
REQ-035 seed_we idx=3 data=0xFFFFFFFF in the same cycle as start with rounds=0 -> ADD gives o3 = 0x00000002; final o3 = 0x00000019 (25).
REQ-036 start and seed_we pulsed while busy -> no restart, no state change; exactly one done pulse occurs.
REQ-037 rst_n low at cycle 30 of a rounds=10 job -> immediately busy=0, o[n]=n; no done pulse; a new rounds=0 job then matches REQ-033.
REQ-038 rounds=255 -> done exactly 2057 cycles after start; busy is continuous until done.

Source files
------------

// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared types and constant tables for the mix sequencer
package mix_pkg;

    localparam int W     = 32;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_MIX,
        ST_SCALE,
        ST_DONE
    } state_t;

    localparam logic [7:0] K_TAB [0:7] = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19};
    localparam logic [7:0] C_TAB [0:7] = '{8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19, 8'd23};

endpackage

// File: rtl/mix_alu.sv
// rtl/mix_alu.sv - shared combinational datapath: a+b-c or a*k+c, modulo 2^W
module mix_alu #(
    parameter int W = 32
) (
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] k,
    output logic [W-1:0] y
);

    always_comb begin
        if (op) y = a * k + c;
        else    y = a + b - c;
    end

endmodule

// File: rtl/mix_sequencer.sv
// rtl/mix_sequencer.sv - ADD / MIX x R / SCALE sequencer over eight state words
module mix_sequencer #(
    parameter int W    = 32,
    parameter int NREG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   rounds,
    input  logic         seed_we,
    input  logic [2:0]   seed_idx,
    input  logic [W-1:0] seed_data,
    input  logic [2:0]   rd_idx,
    output logic [W-1:0] rd_data,
    output logic         busy,
    output logic         done
);
    import mix_pkg::*;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_m1, idx_m2;
    logic [7:0]         r_cnt;
    logic [W-1:0]       o [0:NREG-1];

    logic               upd;
    logic               alu_op;
    logic [W-1:0]       alu_b, alu_c, alu_k, alu_y;
    logic               last;

    assign idx_m1  = idx - IDX_W'(1);
    assign idx_m2  = idx - IDX_W'(2);
    assign last    = (idx == IDX_W'(NREG - 1));
    assign rd_data = o[rd_idx];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        upd       = 1'b0;
        alu_op    = 1'b0;
        alu_b     = '0;
        alu_c     = '0;
        alu_k     = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ADD;
            end
            ST_ADD: begin
                busy  = 1'b1;
                upd   = 1'b1;
                alu_b = W'(idx);
                if (last) state_nxt = (r_cnt != 8'd0) ? ST_MIX : ST_SCALE;
            end
            ST_MIX: begin
                busy  = 1'b1;
                upd   = 1'b1;
                alu_b = o[idx_m1];
                alu_c = o[idx_m2];
                // R is decremented on this same edge, so 1 here means the last pass
                if (last && r_cnt == 8'd1) state_nxt = ST_SCALE;
            end
            ST_SCALE: begin
                busy   = 1'b1;
                upd    = 1'b1;
                alu_op = 1'b1;
                alu_k  = W'(K_TAB[idx]);
                alu_c  = W'(C_TAB[idx]);
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mix_alu #(.W(W)) u_alu (
        .op (alu_op),
        .a  (o[idx]),
        .b  (alu_b),
        .c  (alu_c),
        .k  (alu_k),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            r_cnt <= '0;
            for (int n = 0; n < NREG; n++) o[n] <= W'(n);
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                if (seed_we) o[seed_idx] <= seed_data;
                if (start) begin
                    r_cnt <= rounds;
                    idx   <= '0;
                end
            end
            if (upd) begin
                o[idx] <= alu_y;
                idx    <= idx + IDX_W'(1);
            end
            if (state == ST_MIX && last) r_cnt <= r_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_mix_sequencer.sv
// tb/tb_mix_sequencer.sv - self-checking bench for mix_sequencer
module tb_mix_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, seed_we, busy, done;
    logic [7:0]  rounds;
    logic [2:0]  seed_idx, rd_idx;
    logic [31:0] seed_data, rd_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [8];
    logic [31:0] got [8];
    logic [31:0] e33 [8] = '{32'd3, 32'd11, 32'd27, 32'd53, 32'd101, 32'd147, 32'd223, 32'd289};
    logic [31:0] e34 [8] = '{32'd7, 32'hFFFFFFE7, 32'hFFFFFFDF, 32'd67, 32'd277, 32'd355, 32'd257, 32'd61};
    logic [31:0] kv  [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
    logic [31:0] cv  [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};

    always #5 clk = ~clk;

    mix_sequencer #(.W(32), .NREG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rounds    (rounds),
        .seed_we   (seed_we),
        .seed_idx  (seed_idx),
        .seed_data (seed_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done)
    );

    // Reference: the whole job as three sequential passes over an array.
    task automatic model_run(input int r);
        for (int i = 0; i < 8; i++) mdl[i] = mdl[i] + 32'(i);
        for (int p = 0; p < r; p++)
            for (int i = 0; i < 8; i++)
                mdl[i] = mdl[i] + mdl[(i + 7) % 8] - mdl[(i + 6) % 8];
        for (int i = 0; i < 8; i++) mdl[i] = mdl[i] * kv[i] + cv[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; seed_we = 1'b0; rounds = 8'd0;
        seed_idx = 3'd0; seed_data = 32'd0; rd_idx = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) mdl[n] = 32'(n);
    endtask

    task automatic read_all();
        for (int n = 0; n < 8; n++) begin
            rd_idx = 3'(n);
            #1;
            got[n] = rd_data;
        end
    endtask

    task automatic run_job(input logic [7:0] r, output int lat, output int busy_bad);
        @(negedge clk);
        start = 1'b1; rounds = r;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busy_bad = 0;
        while (done !== 1'b1 && lat < 3000) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== 32'(n)) begin bad++; $display("FAIL reset_o%0d got=%0h exp=%0h", n, got[n], n); end
        end
    endtask

    task automatic test_fixed_vectors();
        int lat, bb;
        do_reset();
        run_job(8'd0, lat, bb);
        total++; if (lat != 17) begin bad++; $display("FAIL r0_latency got=%0d exp=17", lat); end
        total++; if (bb != 0) begin bad++; $display("FAIL r0_busy got=%0d exp=0", bb); end
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== e33[n]) begin bad++; $display("FAIL r0_o%0d got=%0h exp=%0h", n, got[n], e33[n]); end
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end

        do_reset();
        run_job(8'd1, lat, bb);
        total++; if (lat != 25) begin bad++; $display("FAIL r1_latency got=%0d exp=25", lat); end
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== e34[n]) begin bad++; $display("FAIL r1_o%0d got=%0h exp=%0h", n, got[n], e34[n]); end
        end
    endtask

    task automatic test_seed_with_start();
        int lat;
        do_reset();
        @(negedge clk);
        seed_we = 1'b1; seed_idx = 3'd3; seed_data = 32'hFFFFFFFF;
        start = 1'b1; rounds = 8'd0;
        mdl[3] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        seed_we = 1'b0; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rd_idx = 3'd3; #1;
        total++; if (rd_data !== 32'd2) begin bad++; $display("FAIL seed_add_o3 got=%0h exp=2", rd_data); end
        rd_idx = 3'd4; #1;
        total++; if (rd_data !== 32'd4) begin bad++; $display("FAIL partial_o4 got=%0h exp=4", rd_data); end
        lat = 5;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat != 17) begin bad++; $display("FAIL seed_latency got=%0d exp=17", lat); end
        model_run(0);
        read_all();
        total++; if (got[3] !== 32'd25) begin bad++; $display("FAIL seed_final_o3 got=%0h exp=19", got[3]); end
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== mdl[n]) begin bad++; $display("FAIL seed_o%0d got=%0h exp=%0h", n, got[n], mdl[n]); end
        end
    endtask

    task automatic test_busy_ignore();
        int ndone, first_lat;
        do_reset();
        @(negedge clk);
        start = 1'b1; rounds = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_lat = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first_lat == 0) first_lat = cyc;
            end
            start   = (cyc == 3 || cyc == 10 || cyc == 20 || done === 1'b1);
            seed_we = start;
            seed_idx  = 3'($urandom);
            seed_data = $urandom;
            rounds    = 8'd0;
            @(posedge clk); #1;
        end
        start = 1'b0; seed_we = 1'b0;
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
        total++; if (first_lat != 33) begin bad++; $display("FAIL busy_latency got=%0d exp=33", first_lat); end
        model_run(2);
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== mdl[n]) begin bad++; $display("FAIL busy_o%0d got=%0h exp=%0h", n, got[n], mdl[n]); end
        end
    endtask

    task automatic test_reset_mid_job();
        int lat, seen;
        do_reset();
        @(negedge clk);
        start = 1'b1; rounds = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== 32'(n)) begin bad++; $display("FAIL abort_o%0d got=%0h exp=%0h", n, got[n], n); end
        end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; rounds = 8'd0;
        for (int n = 0; n < 8; n++) mdl[n] = 32'(n);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        total++; if (lat != 17) begin bad++; $display("FAIL post_reset_latency got=%0d exp=17", lat); end
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== e33[n]) begin bad++; $display("FAIL post_reset_o%0d got=%0h exp=%0h", n, got[n], e33[n]); end
        end
    endtask

    task automatic test_random();
        int lat, bb, r, nw;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++) begin
                @(negedge clk);
                seed_we = 1'b1; seed_idx = 3'($urandom); seed_data = $urandom;
                mdl[seed_idx] = seed_data;
                @(posedge clk); #1;
                seed_we = 1'b0;
            end
            r = $urandom_range(0, 5);
            run_job(8'(r), lat, bb);
            total++; if (lat != 17 + 8 * r) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, 17 + 8 * r); end
            total++; if (bb != 0) begin bad++; $display("FAIL rand%0d_busy got=%0d exp=0", it, bb); end
            model_run(r);
            read_all();
            for (int n = 0; n < 8; n++) begin
                total++;
                if (got[n] !== mdl[n]) begin bad++; $display("FAIL rand%0d_o%0d got=%0h exp=%0h", it, n, got[n], mdl[n]); end
            end
        end
    endtask

    task automatic test_max_rounds();
        int lat, bb;
        do_reset();
        run_job(8'd255, lat, bb);
        total++; if (lat != 2057) begin bad++; $display("FAIL max_latency got=%0d exp=2057", lat); end
        total++; if (bb != 0) begin bad++; $display("FAIL max_busy got=%0d exp=0", bb); end
        model_run(255);
        read_all();
        for (int n = 0; n < 8; n++) begin
            total++;
            if (got[n] !== mdl[n]) begin bad++; $display("FAIL max_o%0d got=%0h exp=%0h", n, got[n], mdl[n]); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_vectors();
        test_seed_with_start();
        test_busy_ignore();
        test_reset_mid_job();
        test_random();
        test_max_rounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
